// File: rtl/pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_ctrl
//  Purpose  : Power-on / power-down rail sequencer for the AtlasII-EVB-MB
//             CPLD. Brings VIO, VPLL, VMEM, VDDPRE, VDDPDN and the main-board
//             peripheral enable up in order, holds system reset while the
//             rails ramp, then releases reset with a one-cycle POR pulse.
//             Reboot / power-down requests take the rails down in reverse
//             order. Runs from the 32 kHz RTC clock.
//  Ports    : rtc_clk, rst_lo (async, active-low)
//             reboot_req  - 1-cycle pulse, request a power cycle
//             pdn_req     - level, request power-down and hold off
//             vddpdn_cfg  - 1: vddpdn_on follows x_pwr_en while running
//             x_pwr_en    - SoC power-enable input
//             wdog_kick   - 1-cycle watchdog refresh
//             vio_on .. vddpdn_on, main_id0 - rail enables
//             timing_rst  - active-high system reset hold
//             por         - 1-cycle power-on-reset pulse
//             seq_state   - OFF=0 RAMP=1 RUN=2 PDN=3 GAP=4
//             busy        - high except in RUN and OFF
//  Options  : `define PWR_SEQ_WDOG_EN builds a tick-based watchdog that
//             forces a reboot from RUN when not kicked for WDOG_TICKS ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module pwr_seq_ctrl #(
    parameter int          PRESCALE_W = 3,
    parameter logic [7:0]  T_VIO      = 8'h04,
    parameter logic [7:0]  T_VPLL     = 8'h08,
    parameter logic [7:0]  T_VMEM     = 8'h0C,
    parameter logic [7:0]  T_VDDPRE   = 8'h10,
    parameter logic [7:0]  T_VDDPDN   = 8'h14,
    parameter logic [7:0]  T_MB       = 8'h18,
    parameter logic [7:0]  T_RST      = 8'h20,
    parameter logic [7:0]  T_GAP      = 8'h04,
    parameter logic [7:0]  WDOG_TICKS = 8'hF0
) (
    input  logic        rtc_clk,
    input  logic        rst_lo,
    input  logic        reboot_req,
    input  logic        pdn_req,
    input  logic        vddpdn_cfg,
    input  logic        x_pwr_en,
    input  logic        wdog_kick,
    output logic        vio_on,
    output logic        vpll_on,
    output logic        vmem_on,
    output logic        vddpre_on,
    output logic        vddpdn_on,
    output logic        main_id0,
    output logic        timing_rst,
    output logic        por,
    output logic [2:0]  seq_state,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_RAMP = 3'd1,
        ST_RUN  = 3'd2,
        ST_PDN  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    // Rail-off thresholds in PDN, spaced T_GAP ticks apart
    localparam logic [7:0] C_GAP1 = T_GAP;
    localparam logic [7:0] C_GAP2 = C_GAP1 + T_GAP;
    localparam logic [7:0] C_GAP3 = C_GAP2 + T_GAP;
    localparam logic [7:0] C_GAP4 = C_GAP3 + T_GAP;
    localparam logic [7:0] C_GAP5 = C_GAP4 + T_GAP;
    localparam logic [PRESCALE_W-1:0] C_PS_ONE = 1;

    state_t                 r_state;
    logic [PRESCALE_W-1:0]  r_prescale;
    logic [7:0]             r_tick_cnt;
    logic                   r_hold;     // 1: park in OFF after power-down

    logic                   w_tick;
    logic                   w_wdog_trip;
    logic                   w_reboot;

    assign w_tick    = &r_prescale;
    assign w_reboot  = reboot_req | w_wdog_trip;
    assign seq_state = r_state;

`ifdef PWR_SEQ_WDOG_EN
    logic [7:0] r_wdog_cnt;

    // Held at zero outside RUN, so entry to RUN always starts a fresh window
    always_ff @(posedge rtc_clk or negedge rst_lo) begin
        if (!rst_lo) begin
            r_wdog_cnt <= 8'h00;
        end else if ((r_state != ST_RUN) || wdog_kick) begin
            r_wdog_cnt <= 8'h00;
        end else if (w_tick && (r_wdog_cnt != 8'hFF)) begin
            r_wdog_cnt <= r_wdog_cnt + 8'd1;
        end
    end

    assign w_wdog_trip = (r_state == ST_RUN) && (r_wdog_cnt == WDOG_TICKS);
`else
    logic w_unused;

    assign w_wdog_trip = 1'b0;
    assign w_unused    = wdog_kick | (|WDOG_TICKS);
`endif

    always_ff @(posedge rtc_clk or negedge rst_lo) begin
        if (!rst_lo) begin
            r_state    <= ST_RAMP;
            r_prescale <= '0;
            r_tick_cnt <= 8'h00;
            r_hold     <= 1'b0;
            vio_on     <= 1'b0;
            vpll_on    <= 1'b0;
            vmem_on    <= 1'b0;
            vddpre_on  <= 1'b0;
            vddpdn_on  <= 1'b0;
            main_id0   <= 1'b0;
            timing_rst <= 1'b1;
            por        <= 1'b0;
            busy       <= 1'b1;
        end else begin
            // Free-running timebase; every state change below overrides
            // these with a clear so each state times from zero.
            r_prescale <= r_prescale + C_PS_ONE;
            if (w_tick && (r_tick_cnt != 8'hFF)) begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
            end
            por <= 1'b0;

            case (r_state)
                ST_RAMP, ST_RUN: begin
                    if (r_state == ST_RAMP) begin
                        timing_rst <= 1'b1;
                        // Sticky: a rail once on stays on through RAMP
                        if (r_tick_cnt >= T_VIO)    vio_on    <= 1'b1;
                        if (r_tick_cnt >= T_VPLL)   vpll_on   <= 1'b1;
                        if (r_tick_cnt >= T_VMEM)   vmem_on   <= 1'b1;
                        if (r_tick_cnt >= T_VDDPRE) vddpre_on <= 1'b1;
                        if (r_tick_cnt >= T_VDDPDN) vddpdn_on <= 1'b1;
                        if (r_tick_cnt >= T_MB)     main_id0  <= 1'b1;
                    end else begin
                        vddpdn_on <= vddpdn_cfg ? x_pwr_en : 1'b1;
                    end

                    // pdn_req has priority over reboot when both arrive
                    if (pdn_req || w_reboot) begin
                        r_state    <= ST_PDN;
                        r_prescale <= '0;
                        r_tick_cnt <= 8'h00;
                        r_hold     <= pdn_req;
                        main_id0   <= 1'b0;
                        timing_rst <= 1'b1;
                        busy       <= 1'b1;
                    end else if ((r_state == ST_RAMP) && (r_tick_cnt == T_RST)) begin
                        r_state    <= ST_RUN;
                        r_prescale <= '0;
                        r_tick_cnt <= 8'h00;
                        timing_rst <= 1'b0;
                        por        <= 1'b1;
                        busy       <= 1'b0;
                    end
                end

                ST_PDN: begin
                    main_id0   <= 1'b0;
                    timing_rst <= 1'b1;
                    if (r_tick_cnt >= C_GAP1) vddpdn_on <= 1'b0;
                    if (r_tick_cnt >= C_GAP2) vddpre_on <= 1'b0;
                    if (r_tick_cnt >= C_GAP3) vmem_on   <= 1'b0;
                    if (r_tick_cnt >= C_GAP4) vpll_on   <= 1'b0;
                    if (r_tick_cnt >= C_GAP5) vio_on    <= 1'b0;
                    if (r_tick_cnt == C_GAP5) begin
                        r_state    <= r_hold ? ST_OFF : ST_GAP;
                        r_prescale <= '0;
                        r_tick_cnt <= 8'h00;
                        busy       <= ~r_hold;
                    end
                end

                ST_GAP: begin
                    vio_on     <= 1'b0;
                    vpll_on    <= 1'b0;
                    vmem_on    <= 1'b0;
                    vddpre_on  <= 1'b0;
                    vddpdn_on  <= 1'b0;
                    main_id0   <= 1'b0;
                    timing_rst <= 1'b1;
                    if (r_tick_cnt == T_GAP) begin
                        r_state    <= ST_RAMP;
                        r_prescale <= '0;
                        r_tick_cnt <= 8'h00;
                        busy       <= 1'b1;
                    end
                end

                ST_OFF: begin
                    vio_on     <= 1'b0;
                    vpll_on    <= 1'b0;
                    vmem_on    <= 1'b0;
                    vddpre_on  <= 1'b0;
                    vddpdn_on  <= 1'b0;
                    main_id0   <= 1'b0;
                    timing_rst <= 1'b1;
                    busy       <= 1'b0;
                    if (!pdn_req) begin
                        r_state    <= ST_GAP;
                        r_prescale <= '0;
                        r_tick_cnt <= 8'h00;
                        busy       <= 1'b1;
                    end
                end

                default: begin
                    // Illegal encoding: rails off, restart via the gap
                    r_state    <= ST_GAP;
                    r_prescale <= '0;
                    r_tick_cnt <= 8'h00;
                    vio_on     <= 1'b0;
                    vpll_on    <= 1'b0;
                    vmem_on    <= 1'b0;
                    vddpre_on  <= 1'b0;
                    vddpdn_on  <= 1'b0;
                    main_id0   <= 1'b0;
                    timing_rst <= 1'b1;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwr_seq_ctrl
//  Purpose  : Self-checking bench for pwr_seq_ctrl. Directed stimulus in one
//             initial block; expected output vectors are queued with the
//             cycle (rising edges since rst_lo release) at which they must
//             hold and are compared on the falling edge.
//             Vector layout: {vio,vpll,vmem,vddpre,vddpdn,main_id0,
//                             timing_rst,por,busy,seq_state[2:0]}
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwr_seq_ctrl;

    logic       rtc_clk    = 1'b0;
    logic       rst_lo     = 1'b0;
    logic       reboot_req = 1'b0;
    logic       pdn_req    = 1'b0;
    logic       vddpdn_cfg = 1'b0;
    logic       x_pwr_en   = 1'b0;
    logic       wdog_kick  = 1'b0;
    logic       vio_on, vpll_on, vmem_on, vddpre_on, vddpdn_on, main_id0;
    logic       timing_rst, por, busy;
    logic [2:0] seq_state;

    pwr_seq_ctrl dut (
        .rtc_clk    (rtc_clk),
        .rst_lo     (rst_lo),
        .reboot_req (reboot_req),
        .pdn_req    (pdn_req),
        .vddpdn_cfg (vddpdn_cfg),
        .x_pwr_en   (x_pwr_en),
        .wdog_kick  (wdog_kick),
        .vio_on     (vio_on),
        .vpll_on    (vpll_on),
        .vmem_on    (vmem_on),
        .vddpre_on  (vddpre_on),
        .vddpdn_on  (vddpdn_on),
        .main_id0   (main_id0),
        .timing_rst (timing_rst),
        .por        (por),
        .seq_state  (seq_state),
        .busy       (busy)
    );

    always #5 rtc_clk = ~rtc_clk;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge rtc_clk or negedge rst_lo) begin
        if (!rst_lo) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int          at;
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];

    function automatic logic [11:0] obs_vec();
        return {vio_on, vpll_on, vmem_on, vddpre_on, vddpdn_on, main_id0,
                timing_rst, por, busy, seq_state};
    endfunction

    function automatic logic [11:0] pk(logic [5:0] rails, logic tr, logic p,
                                       logic b, logic [2:0] st);
        return {rails, tr, p, b, st};
    endfunction

    task automatic check_vec(input string tag, input logic [11:0] exp);
        logic [11:0] got;
        got = obs_vec();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic exp_at(input int at, input string tag, input logic [11:0] v);
        sb.push_back('{at, tag, v});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge rtc_clk);
    endtask

    // Scoreboard consumer
    always @(negedge rtc_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.at == cyc) else begin
                failures++;
                $error("FAIL %s missed observed_cyc=%0d expected_cyc=%0d", e.tag, cyc, e.at);
            end
            if (e.at == cyc) begin
                checks--;
                check_vec(e.tag, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // ---------------- reset and power-up ----------------
        #23;
        check_vec("reset", pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        @(negedge rtc_clk);
        rst_lo = 1'b1;

        exp_at(32,  "ramp_pre_vio", pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(33,  "vio_rise",     pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(65,  "vpll_rise",    pk(6'b110000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(97,  "vmem_rise",    pk(6'b111000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(129, "vddpre_rise",  pk(6'b111100, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(160, "pre_vddpdn",   pk(6'b111100, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(161, "vddpdn_rise",  pk(6'b111110, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(193, "main_rise",    pk(6'b111111, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(256, "ramp_end",     pk(6'b111111, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(257, "run_por",      pk(6'b111111, 1'b0, 1'b1, 1'b0, 3'd2));
        exp_at(258, "run_por_end",  pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));

        // ---------------- vddpdn follows x_pwr_en ----------------
        wait_cyc(260);
        exp_at(265, "xpwr_hi",      pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(266, "xpwr_lo",      pk(6'b111101, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(270, "xpwr_lo_hold", pk(6'b111101, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(271, "xpwr_hi2",     pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        vddpdn_cfg = 1'b1;
        x_pwr_en   = 1'b1;
        wait_cyc(265);
        x_pwr_en = 1'b0;
        wait_cyc(270);
        x_pwr_en = 1'b1;

        // ---------------- reboot: reverse sequence, gap, ramp ----------------
        wait_cyc(275);
        exp_at(280, "pre_reboot",   pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(281, "pdn_entry",    pk(6'b111110, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(313, "pdn_hold1",    pk(6'b111110, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(314, "vddpdn_off",   pk(6'b111100, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(345, "pdn_hold2",    pk(6'b111100, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(346, "vddpre_off",   pk(6'b111000, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(378, "vmem_off",     pk(6'b110000, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(410, "vpll_off",     pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(441, "pdn_last",     pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(442, "gap_entry",    pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd4));
        exp_at(474, "gap_end",      pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd4));
        exp_at(475, "ramp2_entry",  pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(507, "ramp2_pre",    pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(508, "ramp2_vio",    pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(731, "ramp2_end",    pk(6'b111111, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(732, "run2_por",     pk(6'b111111, 1'b0, 1'b1, 1'b0, 3'd2));
        exp_at(733, "run2_por_end", pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        wait_cyc(280);
        reboot_req = 1'b1;
        wait_cyc(281);
        reboot_req = 1'b0;

        // ---------------- pdn + reboot together: park in OFF ----------------
        wait_cyc(735);
        exp_at(740,  "pre_both",    pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(741,  "both_pdn",    pk(6'b111110, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(901,  "both_last",   pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(902,  "off_entry",   pk(6'b000000, 1'b1, 1'b0, 1'b0, 3'd0));
        exp_at(960,  "off_ign_rb",  pk(6'b000000, 1'b1, 1'b0, 1'b0, 3'd0));
        exp_at(1010, "off_hold",    pk(6'b000000, 1'b1, 1'b0, 1'b0, 3'd0));
        exp_at(1011, "off_to_gap",  pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd4));
        exp_at(1043, "gap3_end",    pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd4));
        exp_at(1044, "ramp3_entry", pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(1077, "ramp3_vio",   pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd1));
        wait_cyc(740);
        pdn_req    = 1'b1;
        reboot_req = 1'b1;
        wait_cyc(741);
        reboot_req = 1'b0;
        wait_cyc(950);
        reboot_req = 1'b1;
        wait_cyc(951);
        reboot_req = 1'b0;
        wait_cyc(1010);
        pdn_req = 1'b0;

        // ---------------- async reset 150 cycles into RAMP ----------------
        wait_cyc(1080);
        exp_at(1194, "pre_async",   pk(6'b111100, 1'b1, 1'b0, 1'b1, 3'd1));
        wait_cyc(1194);
        #2;
        rst_lo = 1'b0;
        #1;
        check_vec("async_reset", pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        @(negedge rtc_clk);
        @(negedge rtc_clk);
        rst_lo = 1'b1;
        exp_at(32,  "rst_pre_vio",  pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(33,  "rst_vio",      pk(6'b100000, 1'b1, 1'b0, 1'b1, 3'd1));
        exp_at(257, "rst_run_por",  pk(6'b111111, 1'b0, 1'b1, 1'b0, 3'd2));

        // ---------------- watchdog ----------------
        wait_cyc(260);
`ifdef PWR_SEQ_WDOG_EN
        exp_at(2177, "wdog_pre",    pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(2178, "wdog_trip",   pk(6'b111110, 1'b1, 1'b0, 1'b1, 3'd3));
        exp_at(2339, "wdog_gap",    pk(6'b000000, 1'b1, 1'b0, 1'b1, 3'd4));
        exp_at(2629, "wdog_rerun",  pk(6'b111111, 1'b0, 1'b1, 1'b0, 3'd2));
        exp_at(4560, "kick_hold1",  pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(5429, "kick_hold2",  pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        for (int k = 0; k < 3; k++) begin
            wait_cyc(3329 + 800 * k);
            wdog_kick = 1'b1;
            wait_cyc(3330 + 800 * k);
            wdog_kick = 1'b0;
        end
        wait_cyc(5432);
`else
        exp_at(2178, "nowdog_run1", pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        exp_at(2400, "nowdog_run2", pk(6'b111111, 1'b0, 1'b0, 1'b0, 3'd2));
        wait_cyc(2403);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
